// File: rtl/fft_buf_pkg.sv
// Shared types and helpers for the FFT frame buffer controller.
// The frame state enum, output FIFO depth and write-address bit reversal live here.
package fft_buf_pkg;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        HOLD   = 2'd1,
        UNLOAD = 2'd2
    } state_t;

    localparam int FIFO_DEPTH = 2;

    // Widest address the bit-reverse helper handles
    localparam int MAX_AW = 16;

    // Reverse the low aw bits of k; bits at and above aw come back as zero
    function automatic logic [MAX_AW-1:0] bitrev(input logic [MAX_AW-1:0] k, input int aw);
        logic [MAX_AW-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_AW; i++) begin
            if (i < aw) begin
                r[i] = k[aw-1-i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_buf_skid.sv
// Two-entry output FIFO for the unload path.
// Each entry holds {last, real, imag}. Reads are issued only when a slot is
// guaranteed to be free, so push never meets a full FIFO.
module fft_buf_skid
    import fft_buf_pkg::*;
#(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         valid,
    output logic [W-1:0] head,
    output logic [1:0]   count
);

    logic [W-1:0] mem [FIFO_DEPTH];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   cnt;
    logic         pop_en;

    assign pop_en = pop && (cnt != 2'd0);
    assign valid  = (cnt != 2'd0);
    assign head   = mem[rd_ptr];
    assign count  = cnt;

    // Storage array; its contents are meaningless while cnt is zero, so it has no reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; reset flushes the FIFO
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop_en) begin
                rd_ptr <= ~rd_ptr;
            end
            cnt <= cnt + 2'(push) - 2'(pop_en);
        end
    end

endmodule

// File: rtl/fft_buf_ctrl.sv
// Frame controller that owns port A of the complex sample RAM.
// The controller loads a frame, holds it for the FFT engine, then unloads it
// in natural order. Defining FFT_BUF_BITREV_EN makes the load write in
// bit-reversed address order for DIT input. Without that macro the load
// writes in natural order.
//
// Handshakes: a beat transfers on a rising clk edge where valid and ready are
// both high. Once valid is raised it stays high, and the payload stays
// constant, until that transfer happens. ready may depend combinationally on
// state but never on valid.
module fft_buf_ctrl
    import fft_buf_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DW     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DW-1:0]     s_real,
    input  logic [DW-1:0]     s_imag,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DW-1:0]     ram_din_real,
    output logic [DW-1:0]     ram_din_imag,
    input  logic [DW-1:0]     ram_dout_real,
    input  logic [DW-1:0]     ram_dout_imag,
    output logic              frame_ready,
    input  logic              proc_done,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DW-1:0]     m_real,
    output logic [DW-1:0]     m_imag,
    output logic              m_last,
    output state_t            dbg_state
);

    localparam int              N        = 2**ADDR_W;
    localparam logic [ADDR_W:0] N_CNT    = (ADDR_W+1)'(N);
    localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W+1)'(N-1);
    localparam int              FW       = 1 + 2*DW;

    state_t              state_q;
    state_t              state_d;
    logic [ADDR_W:0]     wr_cnt;
    logic [ADDR_W:0]     rd_cnt;
    logic                inflight_q;
    logic                last_q;
    logic [ADDR_W-1:0]   wr_addr;
    logic                in_hs;
    logic                out_hs;
    logic                issue;
    logic [2:0]          occ;
    logic                fifo_valid;
    logic [FW-1:0]       fifo_head;
    logic [1:0]          fifo_count;

`ifdef FFT_BUF_BITREV_EN
    assign wr_addr = ADDR_W'(bitrev(MAX_AW'(wr_cnt[ADDR_W-1:0]), ADDR_W));
`else
    assign wr_addr = wr_cnt[ADDR_W-1:0];
`endif

    assign dbg_state = state_q;
    assign m_real    = fifo_head[2*DW-1:DW];
    assign m_imag    = fifo_head[DW-1:0];

    // Read data arrives one cycle after the address, so push it alongside the last flag captured at issue
    fft_buf_skid #(
        .W (FW)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_q),
        .push_data ({last_q, ram_dout_real, ram_dout_imag}),
        .pop       (out_hs),
        .valid     (fifo_valid),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    // Frame state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, RAM port A drive and stream handshakes; every output is quiet while rst is high
    always_comb begin
        state_d      = state_q;
        s_ready      = 1'b0;
        ram_we       = 1'b0;
        ram_addr     = '0;
        ram_din_real = '0;
        ram_din_imag = '0;
        frame_ready  = 1'b0;
        m_valid      = 1'b0;
        m_last       = 1'b0;
        in_hs        = 1'b0;
        out_hs       = 1'b0;
        issue        = 1'b0;
        occ          = 3'(fifo_count) + 3'(inflight_q);
        if (!rst) begin
            case (state_q)
                LOAD: begin
                    s_ready = 1'b1;
                    in_hs   = s_valid;
                    if (in_hs) begin
                        ram_we       = 1'b1;
                        ram_addr     = wr_addr;
                        ram_din_real = s_real;
                        ram_din_imag = s_imag;
                        if (wr_cnt == LAST_CNT) begin
                            state_d = HOLD;
                        end
                    end
                end
                HOLD: begin
                    frame_ready = 1'b1;
                    if (proc_done) begin
                        state_d = UNLOAD;
                    end
                end
                UNLOAD: begin
                    m_valid = fifo_valid;
                    m_last  = fifo_valid && fifo_head[FW-1];
                    out_hs  = m_valid && m_ready;
                    // Keep buffered plus in-flight samples at or below the FIFO depth after this cycle's pop
                    issue   = (rd_cnt < N_CNT) && ((occ - 3'(out_hs)) < 3'(FIFO_DEPTH));
                    if (issue) begin
                        ram_addr = rd_cnt[ADDR_W-1:0];
                    end
                    if (out_hs && m_last) begin
                        state_d = LOAD;
                    end
                end
                default: begin
                    state_d = LOAD;
                end
            endcase
        end
    end

    // Write/read counters and the one-deep record of an outstanding RAM read
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt     <= '0;
            rd_cnt     <= '0;
            inflight_q <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            if (in_hs) begin
                wr_cnt <= (wr_cnt == LAST_CNT) ? '0 : wr_cnt + 1'b1;
            end
            if (state_q == HOLD && proc_done) begin
                rd_cnt <= '0;
            end else if (issue) begin
                rd_cnt <= rd_cnt + 1'b1;
            end
            inflight_q <= issue;
            last_q     <= issue && (rd_cnt == LAST_CNT);
        end
    end

endmodule

// File: tb/tb_fft_buf_ctrl.sv
// Testbench for fft_buf_ctrl with an 8-point frame.
// The port-A/port-B RAM and the FFT engine are modelled here, and the address
// pattern follows FFT_BUF_BITREV_EN.
module tb_fft_buf_ctrl;

    localparam int ADDR_W = 3;
    localparam int DW     = 16;
    localparam int N      = 8;
    localparam int FW     = 1 + 2*DW;
    localparam int WW     = ADDR_W + 2*DW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst;
    logic                 s_valid;
    logic                 s_ready;
    logic [DW-1:0]        s_real;
    logic [DW-1:0]        s_imag;
    logic                 ram_we;
    logic [ADDR_W-1:0]    ram_addr;
    logic [DW-1:0]        ram_din_real;
    logic [DW-1:0]        ram_din_imag;
    logic [DW-1:0]        ram_dout_real;
    logic [DW-1:0]        ram_dout_imag;
    logic                 frame_ready;
    logic                 proc_done;
    logic                 m_valid;
    logic                 m_ready;
    logic [DW-1:0]        m_real;
    logic [DW-1:0]        m_imag;
    logic                 m_last;
    fft_buf_pkg::state_t  dbg_state;

    fft_buf_ctrl #(.ADDR_W(ADDR_W), .DW(DW)) dut (
        .clk           (clk),
        .rst           (rst),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_real        (s_real),
        .s_imag        (s_imag),
        .ram_we        (ram_we),
        .ram_addr      (ram_addr),
        .ram_din_real  (ram_din_real),
        .ram_din_imag  (ram_din_imag),
        .ram_dout_real (ram_dout_real),
        .ram_dout_imag (ram_dout_imag),
        .frame_ready   (frame_ready),
        .proc_done     (proc_done),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_real        (m_real),
        .m_imag        (m_imag),
        .m_last        (m_last),
        .dbg_state     (dbg_state)
    );

    // ---------------- RAM model: port A from DUT, port B from engine ----------------
    logic [DW-1:0]     mem_real [N];
    logic [DW-1:0]     mem_imag [N];
    logic              eng_we;
    logic [ADDR_W-1:0] eng_addr;
    logic [DW-1:0]     eng_real;
    logic [DW-1:0]     eng_imag;

    always @(posedge clk) begin
        if (ram_we) begin
            mem_real[ram_addr] <= ram_din_real;
            mem_imag[ram_addr] <= ram_din_imag;
        end
        if (eng_we) begin
            mem_real[eng_addr] <= eng_real;
            mem_imag[eng_addr] <= eng_imag;
        end
        ram_dout_real <= mem_real[ram_addr];
        ram_dout_imag <= mem_imag[ram_addr];
    end

    // ---------------- scoreboard ----------------
    logic [WW-1:0] wr_exp_q[$];
    logic [FW-1:0] exp_q[$];
    int errors = 0;
    int checks = 0;

    function automatic int tb_rev3(input int k);
        return ((k & 1) << 2) | (k & 2) | ((k >> 2) & 1);
    endfunction

    function automatic int exp_wr_addr(input int k);
`ifdef FFT_BUF_BITREV_EN
        return tb_rev3(k);
`else
        return k;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic load_frame(input int base, input bit gaps, input bit pulse_done);
        int k = 0;
        int budget = 0;
        logic [WW-1:0] e;
        while (k < N && budget < 200) begin
            s_valid   = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            s_real    = DW'(base + k);
            s_imag    = DW'(-(base + k));
            proc_done = pulse_done && (k == 3);
            if (s_valid) wr_exp_q.push_back({ADDR_W'(exp_wr_addr(k)), s_real, s_imag});
            @(negedge clk);
            checks++;
            if (dbg_state !== fft_buf_pkg::LOAD || frame_ready !== 1'b0)
                $display("FAIL load_state k=%0d state=%0d frame_ready=%b want LOAD/0", k, dbg_state, frame_ready);
            checks++;
            if (ram_we !== s_valid) begin
                errors++;
                $display("FAIL load_we k=%0d ram_we=%b want %b", k, ram_we, s_valid);
            end
            if (ram_we === 1'b1) begin
                checks++;
                if (wr_exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL load_write_unexpected addr=%0d", ram_addr);
                end else begin
                    e = wr_exp_q.pop_front();
                    if ({ram_addr, ram_din_real, ram_din_imag} !== e) begin
                        errors++;
                        $display("FAIL load_write k=%0d got addr=%0d re=%0d im=%0d want addr=%0d re=%0d im=%0d",
                                 k, ram_addr, ram_din_real, ram_din_imag, e[WW-1:2*DW], e[2*DW-1:DW], e[DW-1:0]);
                    end
                end
            end
            if (s_valid && s_ready) k++;
            tick();
            budget++;
        end
        s_valid   = 1'b0;
        proc_done = 1'b0;
        checks++;
        if (k != N) begin
            errors++;
            $display("FAIL load_timeout accepted=%0d want %0d", k, N);
        end
        @(negedge clk);
        checks++;
        if (frame_ready !== 1'b1 || s_ready !== 1'b0 || dbg_state !== fft_buf_pkg::HOLD) begin
            errors++;
            $display("FAIL hold_entry frame_ready=%b s_ready=%b state=%0d want 1/0/HOLD", frame_ready, s_ready, dbg_state);
        end
        tick();
    endtask

    // mode 0: engine overwrites with real=10*i, imag=100+i; mode 1: engine leaves loaded data
    task automatic engine_run(input int mode, input int base);
        int v;
        for (int i = 0; i < N; i++) begin
            eng_we   = (mode == 0);
            eng_addr = ADDR_W'(i);
            eng_real = DW'(10 * i);
            eng_imag = DW'(100 + i);
            if (mode == 0) begin
                exp_q.push_back({(i == N-1), DW'(10 * i), DW'(100 + i)});
            end else begin
                v = base + exp_wr_addr(i);
                exp_q.push_back({(i == N-1), DW'(v), DW'(-v)});
            end
            @(negedge clk);
            checks++;
            if (frame_ready !== 1'b1 || s_ready !== 1'b0 || ram_we !== 1'b0) begin
                errors++;
                $display("FAIL hold_outputs i=%0d frame_ready=%b s_ready=%b ram_we=%b want 1/0/0", i, frame_ready, s_ready, ram_we);
            end
            tick();
        end
        eng_we = 1'b0;
    endtask

    // ready_mode 0: always ready; 1: ready pattern 1,0,0 repeating. abort_after>0 resets after that many beats.
    task automatic unload_frame(input int ready_mode, input int abort_after);
        int cyc = 0;
        int popped = 0;
        int issued = 0;
        bit done = 0;
        bit prev_stall = 0;
        logic [FW-1:0] prev_data;
        logic [FW-1:0] e;
        proc_done = 1'b1;
        tick();
        proc_done = 1'b0;
        while (!done && cyc < 200) begin
            m_ready = (ready_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
            @(negedge clk);
            if (cyc < 2) begin
                checks++;
                if (m_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL first_valid_early cyc=%0d m_valid=%b want 0", cyc, m_valid);
                end
            end
            if (cyc == 2) begin
                checks++;
                if (m_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL first_valid_late cyc=2 m_valid=%b want 1", m_valid);
                end
            end
            checks++;
            if (ram_we !== 1'b0 || dbg_state !== fft_buf_pkg::UNLOAD) begin
                errors++;
                $display("FAIL unload_state cyc=%0d ram_we=%b state=%0d want 0/UNLOAD", cyc, ram_we, dbg_state);
            end
            if (prev_stall) begin
                checks++;
                if (m_valid !== 1'b1 || {m_last, m_real, m_imag} !== prev_data) begin
                    errors++;
                    $display("FAIL stall_hold cyc=%0d got v=%b re=%0d im=%0d want v=1 re=%0d im=%0d",
                             cyc, m_valid, m_real, m_imag, prev_data[2*DW-1:DW], prev_data[DW-1:0]);
                end
            end
            if (issued < N && ram_addr == ADDR_W'(issued)) issued++;
            if (m_valid === 1'b1 && m_ready === 1'b1) begin
                popped++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unload_extra re=%0d im=%0d", m_real, m_imag);
                end else begin
                    e = exp_q.pop_front();
                    if ({m_last, m_real, m_imag} !== e) begin
                        errors++;
                        $display("FAIL unload_data beat=%0d got last=%b re=%0d im=%0d want last=%b re=%0d im=%0d",
                                 popped, m_last, m_real, m_imag, e[FW-1], e[2*DW-1:DW], e[DW-1:0]);
                    end
                end
                if (popped == N) done = 1;
            end
            checks++;
            if (issued - popped > 2) begin
                errors++;
                $display("FAIL outstanding cyc=%0d got %0d want <=2", cyc, issued - popped);
            end
            prev_stall = (m_valid === 1'b1) && (m_ready === 1'b0);
            prev_data  = {m_last, m_real, m_imag};
            if (abort_after > 0 && popped == abort_after) done = 1;
            cyc++;
            tick();
        end
        m_ready = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL unload_timeout beats=%0d want %0d", popped, N);
        end
        if (abort_after > 0) begin
            rst = 1'b1;
            @(negedge clk);
            checks++;
            if (m_valid !== 1'b0 || s_ready !== 1'b0) begin
                errors++;
                $display("FAIL rst_outputs m_valid=%b s_ready=%b want 0/0", m_valid, s_ready);
            end
            tick();
            rst = 1'b0;
            exp_q.delete();
        end
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1 || dbg_state !== fft_buf_pkg::LOAD) begin
            errors++;
            $display("FAIL back_to_load m_valid=%b s_ready=%b state=%0d want 0/1/LOAD", m_valid, s_ready, dbg_state);
        end
        tick();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        tick();
        @(negedge clk);
        checks++;
        if ({s_ready, ram_we, frame_ready, m_valid, m_last} !== 5'b0 || ram_addr !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %b addr=%0d want 00000 addr=0",
                     {s_ready, ram_we, frame_ready, m_valid, m_last}, ram_addr);
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b1 || dbg_state !== fft_buf_pkg::LOAD) begin
            errors++;
            $display("FAIL reset_release s_ready=%b state=%0d want 1/LOAD", s_ready, dbg_state);
        end
        tick();
    endtask

    task automatic test_load_with_stray_done();
        load_frame(0, 1'b0, 1'b1);
    endtask

    task automatic test_unload_stream();
        engine_run(0, 0);
        unload_frame(0, 0);
    endtask

    task automatic test_backpressure();
        load_frame(20, 1'b1, 1'b0);
        engine_run(1, 20);
        unload_frame(1, 0);
    endtask

    task automatic test_reset_mid_unload();
        load_frame(40, 1'b0, 1'b0);
        engine_run(0, 0);
        unload_frame(0, 5);
    endtask

    task automatic test_back_to_back();
        load_frame(60, 1'b1, 1'b0);
        engine_run(1, 60);
        unload_frame(0, 0);
    endtask

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_real = '0; s_imag = '0;
        proc_done = 1'b0; m_ready = 1'b0;
        eng_we = 1'b0; eng_addr = '0; eng_real = '0; eng_imag = '0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_load_with_stray_done();
        test_unload_stream();
        test_backpressure();
        test_reset_mid_unload();
        test_back_to_back();
        checks++;
        if (wr_exp_q.size() != 0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_expected wr=%0d out=%0d want 0/0", wr_exp_q.size(), exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fft_buf_ctrl.md
Name: fft_buf_ctrl

Overview:
- Frame controller that owns port A of the 4096-point complex sample RAM.
- LOAD: accepts a streaming input frame and writes it into RAM, optionally in bit-reversed order.
- HOLD: hands the frame to the FFT engine, which uses port B and is not routed through this block.
- UNLOAD: after the engine signals completion, reads the frame back in natural order and streams it out with ready/valid backpressure, absorbing the RAM's 1-cycle read latency.

Parameters:
- ADDR_W, 12, log2 of frame length; N = 2**ADDR_W samples per frame.
- DW, 16, signed width of each real/imag component.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- s_valid  in  1  input sample valid
- s_ready  out  1  input sample ready
- s_real, s_imag  in  DW each  input sample, signed
- ram_we  out  1  RAM port A write enable
- ram_addr  out  ADDR_W  RAM port A address
- ram_din_real, ram_din_imag  out  DW each  RAM port A write data
- ram_dout_real, ram_dout_imag  in  DW each  RAM port A read data, valid 1 cycle after address
- frame_ready  out  1  high in HOLD: frame is loaded and the engine owns the RAM
- proc_done  in  1  single-cycle pulse from the engine: processing finished
- m_valid  out  1  output sample valid
- m_ready  in  1  output sample ready
- m_real, m_imag  out  DW each  output sample, signed
- m_last  out  1  high with output sample N-1

Behaviour:
- Clocking/reset: single clock domain; reset is synchronous and active-high on clk.
- Reset values: state=LOAD, wr_cnt=0, rd_cnt=0, FIFO empty, in-flight=0.
- Outputs during rst: s_ready=0, ram_we=0, frame_ready=0, m_valid=0, m_last=0; ram_addr/data=0.
- LOAD:
  - s_ready=1 (first cycle after rst deasserts onward).
  - Input handshake = s_valid & s_ready.
  - On handshake: ram_we=1 (combinational), ram_addr=wr_addr(wr_cnt), ram_din=s_real/s_imag, wr_cnt++.
  - No handshake: ram_we=0.
  - Handshake with wr_cnt==N-1: wr_cnt wraps to 0; next state HOLD.
- HOLD:
  - s_ready=0, ram_we=0, frame_ready=1.
  - proc_done=1: next state UNLOAD, rd_cnt=0.
  - proc_done in any other state: ignored.
- UNLOAD:
  - Read issue condition: rd_cnt<N and (fifo_count + inflight - pop) < 2, where pop = m_valid & m_ready in the same cycle.
  - On issue: ram_addr=rd_cnt, rd_cnt++, inflight=1.
  - Cycle after issue: ram_dout is pushed into the 2-entry output FIFO.
  - m_valid = FIFO non-empty; m_real/m_imag = FIFO head.
  - m_last = 1 when the head sample's index is N-1.
  - Handshake with m_last=1: next state LOAD; FIFO is empty by construction.
- Latency:
  - First m_valid appears 2 cycles after entering UNLOAD.
  - Sustained throughput is 1 sample/cycle while m_ready=1.
  - When m_ready=0: at most 2 samples buffered; no reads issued; no data lost.
- m_real/m_imag stay stable while m_valid=1 and m_ready=0.
- ram_we=0 in HOLD and UNLOAD.
- Reset mid-frame: any state returns to LOAD, FIFO flushed, counters 0. RAM contents are not cleared; the partial frame is discarded.
- Arithmetic: no arithmetic on sample data; counters are ADDR_W+1 bits, compared against N.

Optional Feature:
- Macro: FFT_BUF_BITREV_EN.
- Defined: wr_addr(k) = bit-reverse of k over ADDR_W bits, giving DIT input ordering. Example, ADDR_W=3: k=1 -> 4, k=3 -> 6.
- Undefined: wr_addr(k) = k (natural order).
- Unload is always natural order in both cases.

Decomposition:
- Package fft_buf_pkg:
  - state enum {LOAD, HOLD, UNLOAD}
  - function bitrev(k, ADDR_W)
  - localparam FIFO_DEPTH = 2
- Sub-module fft_buf_skid: 2-entry output FIFO carrying {last, real, imag}, with push, pop, count outputs.

Test Plan (all with ADDR_W=3, N=8):
- Load 8 samples real=k, imag=-k, s_valid always 1, macro defined -> writes hit addresses 0,4,2,6,1,5,3,7; frame_ready=1 the cycle after the 8th handshake; s_ready=0 there.
- Macro undefined, same stimulus -> writes hit addresses 0..7 in order.
- HOLD, engine writes port B address i with real=10*i; pulse proc_done; m_ready=1 -> m_valid first at cycle 2 after UNLOAD entry; 8 consecutive samples with real=0,10,...,70; m_last only on the 8th.
- UNLOAD with m_ready toggling 1,0,0,1,... -> no sample dropped or duplicated, outputs held stable while stalled, at most 2 reads outstanding+buffered.
- proc_done pulsed during LOAD -> ignored, no state change; second frame loads correctly after the first unload.
- rst asserted for 1 cycle after 5 UNLOAD handshakes -> m_valid=0 next cycle, state LOAD, s_ready=1; next frame starts at index 0.
